// File: rtl/pcs_tx_code_group.sv
// rtl/pcs_tx_code_group.sv - 1000BASE-X PCS transmit code-group generator
//
// Turns the GMII octet stream into one 8b/10b code group per clock, inserting
// /I1/ /I2/ /S/ /T/ /R/ /V/ and tracking running disparity.
// Code-group bit order: [9] = a (first on the wire) ... [0] = j.
//
// Ports:
//   clk           clock, one code group per rising edge
//   reset         asynchronous, active-high reset
//   tx_en         frame enable from the MAC
//   tx_er         transmit error, only meaningful with tx_en=1
//   txd           octet, bits HGFEDCBA
//   tx_code_group registered code group
//   tx_even       1 when tx_code_group occupies an even slot
//   tx_rd         running disparity after tx_code_group (0 = negative)
//   tx_align_err  one-cycle pulse: tx_en rose on an odd slot
`timescale 1ns/1ps
module pcs_tx_code_group #(
    parameter int CG_WIDTH = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tx_en,
    input  logic                tx_er,
    input  logic [7:0]          txd,
    output logic [CG_WIDTH-1:0] tx_code_group,
    output logic                tx_even,
    output logic                tx_rd,
    output logic                tx_align_err
);

    // Special code groups in their RD- form; every one used here has an RD+
    // form that is the bitwise complement.
    localparam logic [9:0] K28_5 = 10'b0011111010;
    localparam logic [9:0] K27_7 = 10'b1101101000;  // /S/
    localparam logic [9:0] K29_7 = 10'b1011101000;  // /T/
    localparam logic [9:0] K23_7 = 10'b1110101000;  // /R/
    localparam logic [9:0] K30_7 = 10'b0111101000;  // /V/

    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] D16_2 = 8'h50;

    typedef enum logic [2:0] {
        S_IDLE_K,
        S_IDLE_D,
        S_DATA,
        S_EOP_R1,
        S_EOP_R2
    } state_t;

    state_t              state, state_next;
    logic                start_pend, start_next;
    logic                even_slot;   // parity of the slot being produced now
    logic                align_next;
    logic [CG_WIDTH-1:0] cg_next;
    logic                rd_next;

    // 5b/6b table, RD- column (abcdei)
    function automatic logic [5:0] enc_6b(input logic [4:0] x);
        logic [5:0] s;
        s = 6'b100111;
        case (x)
            5'd0:  s = 6'b100111;
            5'd1:  s = 6'b011101;
            5'd2:  s = 6'b101101;
            5'd3:  s = 6'b110001;
            5'd4:  s = 6'b110101;
            5'd5:  s = 6'b101001;
            5'd6:  s = 6'b011001;
            5'd7:  s = 6'b111000;
            5'd8:  s = 6'b111001;
            5'd9:  s = 6'b100101;
            5'd10: s = 6'b010101;
            5'd11: s = 6'b110100;
            5'd12: s = 6'b001101;
            5'd13: s = 6'b101100;
            5'd14: s = 6'b011100;
            5'd15: s = 6'b010111;
            5'd16: s = 6'b011011;
            5'd17: s = 6'b100011;
            5'd18: s = 6'b010011;
            5'd19: s = 6'b110010;
            5'd20: s = 6'b001011;
            5'd21: s = 6'b101010;
            5'd22: s = 6'b011010;
            5'd23: s = 6'b111010;
            5'd24: s = 6'b110011;
            5'd25: s = 6'b100110;
            5'd26: s = 6'b010110;
            5'd27: s = 6'b110110;
            5'd28: s = 6'b001110;
            5'd29: s = 6'b101110;
            5'd30: s = 6'b011110;
            5'd31: s = 6'b101011;
        endcase
        return s;
    endfunction

    // 3b/4b table, RD- column (fghj); alt selects A7 instead of P7
    function automatic logic [3:0] enc_4b(input logic [2:0] y, input logic alt);
        logic [3:0] s;
        s = 4'b1011;
        case (y)
            3'd0: s = 4'b1011;
            3'd1: s = 4'b1001;
            3'd2: s = 4'b0101;
            3'd3: s = 4'b1100;
            3'd4: s = 4'b1101;
            3'd5: s = 4'b1010;
            3'd6: s = 4'b0110;
            3'd7: s = alt ? 4'b0111 : 4'b1110;
        endcase
        return s;
    endfunction

    function automatic logic [9:0] enc_data(input logic [7:0] d, input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] s6;
        logic [3:0] s4;
        logic       unbal6, unbal4, rd_mid, alt;
        x      = d[4:0];
        y      = d[7:5];
        s6     = enc_6b(x);
        unbal6 = ($countones(s6) != 3);
        // D7 is balanced but still has distinct RD-/RD+ forms
        if (rd && (unbal6 || x == 5'd7))
            s6 = ~s6;
        rd_mid = rd ^ unbal6;
        // A7 avoids a run of five identical bits across the sub-block seam
        alt = (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
              ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14));
        s4     = enc_4b(y, alt);
        unbal4 = ($countones(s4) != 2);
        if (rd_mid && (unbal4 || y == 3'd3))
            s4 = ~s4;
        return {s6, s4};
    endfunction

    function automatic logic [9:0] sel_k(input logic [9:0] k, input logic rd);
        return rd ? ~k : k;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE_K;
            start_pend    <= 1'b0;
            even_slot     <= 1'b1;
            tx_code_group <= '0;
            tx_even       <= 1'b0;
            tx_rd         <= 1'b0;
            tx_align_err  <= 1'b0;
        end else begin
            state         <= state_next;
            start_pend    <= start_next;
            even_slot     <= ~even_slot;
            tx_code_group <= cg_next;
            tx_even       <= even_slot;
            tx_rd         <= rd_next;
            tx_align_err  <= align_next;
        end
    end

    always_comb begin
        state_next = state;
        start_next = start_pend;
        align_next = 1'b0;
        cg_next    = '0;
        case (state)
            S_IDLE_K: begin
                if (tx_en || start_pend) begin
                    cg_next    = sel_k(K27_7, tx_rd);
                    start_next = 1'b0;
                    state_next = S_DATA;
                end else begin
                    cg_next    = sel_k(K28_5, tx_rd);
                    state_next = S_IDLE_D;
                end
            end
            S_IDLE_D: begin
                // RD+ after K28.5 needs the disparity-flipping /I2/ to get back to RD-
                cg_next    = enc_data(tx_rd ? D16_2 : D5_6, tx_rd);
                state_next = S_IDLE_K;
                if (tx_en) begin
                    align_next = 1'b1;
                    start_next = 1'b1;
                end
            end
            S_DATA: begin
                if (!tx_en) begin
                    cg_next    = sel_k(K29_7, tx_rd);
                    state_next = S_EOP_R1;
                end else if (tx_er) begin
                    cg_next = sel_k(K30_7, tx_rd);
                end else begin
                    cg_next = enc_data(txd, tx_rd);
                end
            end
            S_EOP_R1: begin
                cg_next    = sel_k(K23_7, tx_rd);
                // a second /R/ keeps the next K28.5 on an even slot
                state_next = even_slot ? S_EOP_R2 : S_IDLE_K;
            end
            S_EOP_R2: begin
                cg_next    = sel_k(K23_7, tx_rd);
                state_next = S_IDLE_K;
            end
            default: state_next = S_IDLE_K;
        endcase
        rd_next = tx_rd ^ ($countones(cg_next) != 5);
    end

endmodule
